parking_lot_ctrl: RTL and testbench

Parametrised successor to the single-garage parking controller. It tracks occupancy of N_SPOTS individual spots with a bitmap and assigns each entering car the lowest-index free spot. It runs a timed door sequence for entry and exit, queues events that arrive while the door is busy, and flags illegal exits. It sits between the gate sensors and the display/light drivers at the top level.

---
 rtl/parking_lot_ctrl.sv | 174 +++++++++++++++++
 tb/tb_parking_lot_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl: N-spot parking controller.
// Tracks spot occupancy as a bitmap, gives each entering car the lowest free
// spot, runs a timed door sequence per admitted event and queues one pending
// entry and one pending exit while the door is busy.
module parking_lot_ctrl #(
  parameter int N_SPOTS     = 4,
  parameter int IDX_W       = 2,
  parameter int CNT_W       = 3,
  parameter int DOOR_CYCLES = 8
) (
  input  logic               clk_in,
  input  logic               RST,
  input  logic               car_in,
  input  logic               car_out,
  input  logic [IDX_W-1:0]   Ex,
  output logic               entry1,
  output logic               exit1,
  output logic               reject,
  output logic [CNT_W-1:0]   capacity,
  output logic [IDX_W-1:0]   nearest_park,
  output logic               light_door_open,
  output logic               light_full_garage,
  output logic [N_SPOTS-1:0] parking_lights
);

  localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DOOR_IN  = 2'd1,
    S_DOOR_OUT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DOOR_W-1:0]   cnt_q, cnt_d;
  logic [N_SPOTS-1:0]  occ_q, occ_d;

  // Sensor history and arming: a sensor must be seen low after reset before
  // its next rise counts, so a car parked on the sensor across reset release
  // does not fabricate a request.
  logic in_q, out_q, arm_in_q, arm_out_q;
  logic req_in, req_out;

  logic               pend_in_q, pend_in_d;
  logic               pend_out_q, pend_out_d;
  logic [IDX_W-1:0]   pend_ex_q, pend_ex_d;
  logic               clr_in, clr_out;

  logic entry_q, entry_d, exit_q, exit_d, reject_q, reject_d;

  logic [CNT_W-1:0] used_cnt, free_cnt;
  logic [IDX_W-1:0] near_idx;
  logic             ex_ok;

  // Free-spot count and lowest-free-spot encode from the occupancy bitmap.
  always_comb begin
    used_cnt = '0;
    for (int i = 0; i < N_SPOTS; i++) used_cnt = used_cnt + CNT_W'(occ_q[i]);
    free_cnt = CNT_W'(N_SPOTS) - used_cnt;
    near_idx = '0;
    for (int i = N_SPOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) near_idx = IDX_W'(i);
    end
  end

  // An exit is legal only for an in-range, currently occupied spot.
  always_comb begin
    ex_ok = 1'b0;
    if ({1'b0, pend_ex_q} < (IDX_W + 1)'(N_SPOTS)) ex_ok = occ_q[pend_ex_q];
  end

  // Rising-edge requests and one-deep pending flags; a repeat request while
  // its flag is still set is dropped.
  always_comb begin
    req_in     = arm_in_q  & ~in_q  & car_in;
    req_out    = arm_out_q & ~out_q & car_out;
    pend_in_d  = pend_in_q  ? ~clr_in  : req_in;
    pend_out_d = pend_out_q ? ~clr_out : req_out;
    pend_ex_d  = (req_out && !pend_out_q) ? Ex : pend_ex_q;
  end

  // Next-state and service logic: exits take priority over entries in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    occ_d    = occ_q;
    clr_in   = 1'b0;
    clr_out  = 1'b0;
    entry_d  = 1'b0;
    exit_d   = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_out_q) begin
          clr_out = 1'b1;
          if (ex_ok) begin
            occ_d[pend_ex_q] = 1'b0;
            exit_d           = 1'b1;
            state_d          = S_DOOR_OUT;
            cnt_d            = '0;
          end else begin
            reject_d = 1'b1;
          end
        end else if (pend_in_q) begin
          clr_in = 1'b1;
          if (free_cnt != '0) begin
            occ_d[near_idx] = 1'b1;
            entry_d         = 1'b1;
            state_d         = S_DOOR_IN;
            cnt_d           = '0;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_DOOR_IN, S_DOOR_OUT: begin
        if (cnt_q == DOOR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, occupancy, pending and pulse registers.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      occ_q      <= '0;
      in_q       <= 1'b0;
      out_q      <= 1'b0;
      arm_in_q   <= 1'b0;
      arm_out_q  <= 1'b0;
      pend_in_q  <= 1'b0;
      pend_out_q <= 1'b0;
      pend_ex_q  <= '0;
      entry_q    <= 1'b0;
      exit_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      occ_q      <= occ_d;
      in_q       <= car_in;
      out_q      <= car_out;
      arm_in_q   <= arm_in_q  | ~car_in;
      arm_out_q  <= arm_out_q | ~car_out;
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
      pend_ex_q  <= pend_ex_d;
      entry_q    <= entry_d;
      exit_q     <= exit_d;
      reject_q   <= reject_d;
    end
  end

  assign entry1            = entry_q;
  assign exit1             = exit_q;
  assign reject            = reject_q;
  assign capacity          = free_cnt;
  assign nearest_park      = near_idx;
  assign parking_lights    = occ_q;
  assign light_door_open   = (state_q != S_IDLE);
  assign light_full_garage = (free_cnt == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Scoreboard bench for parking_lot_ctrl: stimulus pushes expected pulse
// events, a negedge monitor pops and compares whenever a pulse appears.
module tb_parking_lot_ctrl;

  logic       clk_in = 1'b0;
  logic       RST = 1'b1;
  logic       car_in = 1'b0, car_out = 1'b0;
  logic [1:0] Ex = '0;
  logic       entry1, exit1, reject;
  logic [2:0] capacity;
  logic [1:0] nearest_park;
  logic       light_door_open, light_full_garage;
  logic [3:0] parking_lights;

  parking_lot_ctrl #(.N_SPOTS(4), .IDX_W(2), .CNT_W(3), .DOOR_CYCLES(8)) dut (
    .clk_in(clk_in), .RST(RST), .car_in(car_in), .car_out(car_out), .Ex(Ex),
    .entry1(entry1), .exit1(exit1), .reject(reject), .capacity(capacity),
    .nearest_park(nearest_park), .light_door_open(light_door_open),
    .light_full_garage(light_full_garage), .parking_lights(parking_lights)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0] kind;   // {entry1, exit1, reject}
    logic [3:0] lights;
    logic [2:0] cap;
    logic [1:0] near;
    logic       full;
    logic       door;
    int         cyc;
  } exp_t;

  localparam logic [2:0] K_ENT = 3'b100, K_EXT = 3'b010, K_REJ = 3'b001;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  int   door_len = 0;

  always @(posedge clk_in) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] k, input logic [3:0] l,
                              input logic [2:0] c, input logic [1:0] n);
    exp_t e;
    e.kind = k; e.lights = l; e.cap = c; e.near = n;
    e.full = (c == 3'd0); e.door = (k != K_REJ); e.cyc = 0;
    return e;
  endfunction

  // Monitor: pulse events against the scoreboard, door-open run lengths.
  always @(negedge clk_in) begin
    exp_t e;
    if (RST) door_len = 0;
    else begin
      if (light_door_open) door_len++;
      else if (door_len != 0) begin
        chk("door_len", door_len, 8);
        door_len = 0;
      end
      if (entry1 | exit1 | reject) begin
        if (q.size() == 0) chk("unexpected_pulse", {entry1, exit1, reject}, 3'b000);
        else begin
          e = q.pop_front();
          chk("pulse_kind", {entry1, exit1, reject}, e.kind);
          chk("pulse_state",
              {parking_lights, 1'b0, capacity, 2'b0, nearest_park, 3'b0, light_full_garage, 3'b0, light_door_open},
              {e.lights, 1'b0, e.cap, 2'b0, e.near, 3'b0, e.full, 3'b0, e.door});
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk(nm, {entry1, exit1, reject, light_door_open, light_full_garage, parking_lights, capacity, nearest_park},
            {5'b00000, 4'b0000, 3'd4, 2'd0});
  endtask

  task automatic ev_in(input exp_t e);
    @(posedge clk_in); #1;
    car_in = 1'b1;
    e.cyc = cyc + 2;
    q.push_back(e);
    repeat (2) @(posedge clk_in);
    #1 car_in = 1'b0;
    repeat (12) @(posedge clk_in);
  endtask

  task automatic ev_out(input logic [1:0] ex, input exp_t e);
    @(posedge clk_in); #1;
    car_out = 1'b1;
    Ex = ex;
    e.cyc = cyc + 2;
    q.push_back(e);
    repeat (2) @(posedge clk_in);
    #1 car_out = 1'b0;
    Ex = 2'd0;
    repeat (12) @(posedge clk_in);
  endtask

  initial begin
    exp_t e1, e2;
    #1 check_reset_outputs("reset_during");
    repeat (3) @(posedge clk_in);
    #1 RST = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 check_reset_outputs("reset_after");

    // Fill the lot one car at a time, then one too many.
    ev_in(mk(K_ENT, 4'b0001, 3'd3, 2'd1));
    ev_in(mk(K_ENT, 4'b0011, 3'd2, 2'd2));
    ev_in(mk(K_ENT, 4'b0111, 3'd1, 2'd3));
    ev_in(mk(K_ENT, 4'b1111, 3'd0, 2'd0));
    ev_in(mk(K_REJ, 4'b1111, 3'd0, 2'd0));

    // Exit from the middle, refill that spot.
    ev_out(2'd2, mk(K_EXT, 4'b1011, 3'd1, 2'd2));
    ev_in(mk(K_ENT, 4'b1111, 3'd0, 2'd0));

    // Exit spot 3, then an illegal exit from the now-free spot 3.
    ev_out(2'd3, mk(K_EXT, 4'b0111, 3'd1, 2'd3));
    ev_out(2'd3, mk(K_REJ, 4'b0111, 3'd1, 2'd3));
    ev_in(mk(K_ENT, 4'b1111, 3'd0, 2'd0));

    // Full lot: entry and exit on the same clock; exit first, entry after
    // the door plus one closed cycle. A third entry edge mid-door is dropped.
    @(posedge clk_in); #1;
    car_in = 1'b1; car_out = 1'b1; Ex = 2'd0;
    e1 = mk(K_EXT, 4'b1110, 3'd1, 2'd0); e1.cyc = cyc + 2;
    e2 = mk(K_ENT, 4'b1111, 3'd0, 2'd0); e2.cyc = cyc + 11;
    q.push_back(e1);
    q.push_back(e2);
    repeat (2) @(posedge clk_in);
    #1 car_in = 1'b0; car_out = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 car_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 car_in = 1'b0;
    repeat (16) @(posedge clk_in);
    #1 chk("sim_final_lights", parking_lights, 4'b1111);

    // Get to 0111 with the door open on an entry, then reset mid-door.
    ev_out(2'd3, mk(K_EXT, 4'b0111, 3'd1, 2'd3));
    ev_out(2'd2, mk(K_EXT, 4'b0011, 3'd2, 2'd2));
    @(posedge clk_in); #1;
    car_in = 1'b1;
    e1 = mk(K_ENT, 4'b0111, 3'd1, 2'd3); e1.cyc = cyc + 2;
    q.push_back(e1);
    repeat (4) @(posedge clk_in);
    #1 chk("door_before_reset", light_door_open, 1'b1);
    RST = 1'b1;
    #1 check_reset_outputs("reset_mid_door");
    repeat (2) @(posedge clk_in);
    #1 RST = 1'b0;
    repeat (6) @(posedge clk_in);
    #1 check_reset_outputs("held_sensor_after_reset");
    car_in = 1'b0;
    repeat (2) @(posedge clk_in);
    ev_in(mk(K_ENT, 4'b0001, 3'd3, 2'd1));

    repeat (4) @(posedge clk_in);
    #1 chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
